// File: rtl/systolic_quant_pkg.sv
// Shared types and helpers for the systolic quantising tile engine.
package systolic_quant_pkg;

    // Per-column right-shift field width (shift range 0..63).
    localparam int SHIFT_WIDTH = 6;

    // Working width of the saturation helpers; wide enough for any
    // intermediate the datapath produces.
    localparam int SAT_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        QUANT,
        DRAIN
    } state_e;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] hi;
        lo = '1;
        lo = lo <<< (w - 1);
        hi = ~lo;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // Clamp to the accumulator range.
    function automatic logic signed [SAT_W-1:0] sat_acc(
        input logic signed [SAT_W-1:0] v,
        input int                      acc_width
    );
        return sat_signed(v, acc_width);
    endfunction

    // Clamp to the output data range.
    function automatic logic signed [SAT_W-1:0] sat_data(
        input logic signed [SAT_W-1:0] v,
        input int                      data_width
    );
        return sat_signed(v, data_width);
    endfunction

endpackage

// File: rtl/systolic_quant_tile_engine_requant_lane.sv
// One output column's requantiser: stage 1 multiplies by the column scale,
// stage 2 rounds half up, shifts, adds the zero point and saturates.
module requant_lane
    import systolic_quant_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic signed [ACC_WIDTH-1:0]   acc_i,
    input  logic [ACC_WIDTH-1:0]          scale_i,
    input  logic [SHIFT_WIDTH-1:0]        shift_i,
    input  logic signed [DATA_WIDTH-1:0]  zero_point_i,
    output logic [DATA_WIDTH-1:0]         q_o
);

    // Signed acc times unsigned scale needs one extra bit for the sign.
    localparam int PW = 2 * ACC_WIDTH + 1;
    // One more bit so adding the rounding constant cannot wrap.
    localparam int RW = PW + 1;

    logic signed [PW-1:0]    p_d;
    logic signed [PW-1:0]    p_q;
    logic signed [RW-1:0]    p_ext;
    logic signed [RW-1:0]    rnd;
    logic signed [RW-1:0]    r;
    logic signed [SAT_W-1:0] q_wide;
    logic [DATA_WIDTH-1:0]   q_d;
    logic [DATA_WIDTH-1:0]   q_q;

    // Stage 1 product; scale is zero-extended so it is always non-negative.
    always_comb begin
        p_d = PW'(acc_i) * $signed(PW'(scale_i));
    end

    // Stage 2: round half up, arithmetic shift, offset and clamp.
    always_comb begin
        p_ext = RW'(p_q);
        rnd   = '0;
        if (shift_i != '0) begin
            rnd = RW'(1) <<< (shift_i - SHIFT_WIDTH'(1));
            r   = (p_ext + rnd) >>> shift_i;
        end else begin
            r   = p_ext;
        end
        q_wide = SAT_W'(r) + SAT_W'(zero_point_i);
        q_d    = DATA_WIDTH'(sat_data(q_wide, DATA_WIDTH));
    end

    // Pipeline registers for both stages.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            p_q <= '0;
            q_q <= '0;
        end else begin
            p_q <= p_d;
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/systolic_quant_tile_engine.sv
// Output-stationary ROWS x COLS tile: accumulate over k_len beats,
// requantise per column, then stream the result out row by row.
module systolic_quant_tile_engine
    import systolic_quant_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int K_WIDTH    = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  start_i,
    input  logic [K_WIDTH-1:0]                    k_len_i,
    input  logic [COLS-1:0][ACC_WIDTH-1:0]        scale_i,
    input  logic [COLS-1:0][SHIFT_WIDTH-1:0]      shift_i,
    input  logic [DATA_WIDTH-1:0]                 zero_point_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [ROWS-1:0][DATA_WIDTH-1:0]       a_vec_i,
    input  logic [COLS-1:0][DATA_WIDTH-1:0]       b_vec_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [COLS-1:0][DATA_WIDTH-1:0]       out_row_o,
    output logic [$clog2(ROWS)-1:0]               out_row_idx_o,
    output logic                                  out_last_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  acc_overflow_o
);

    localparam int RIW    = $clog2(ROWS);
    localparam int QCW    = $clog2(ROWS + 2);
    localparam int PROD_W = 2 * DATA_WIDTH;

    typedef logic [COLS-1:0][DATA_WIDTH-1:0] row_t;

    state_e                           state_q;
    state_e                           state_d;
    logic [K_WIDTH-1:0]               k_len_q;
    logic [K_WIDTH-1:0]               beat_q;
    logic [COLS-1:0][ACC_WIDTH-1:0]   scale_q;
    logic [COLS-1:0][SHIFT_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0]            zero_point_q;
    logic signed [ACC_WIDTH-1:0]      acc_q [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]      acc_d [ROWS][COLS];
    logic                             acc_sat;
    logic                             acc_overflow_q;
    logic [QCW-1:0]                   qcnt_q;
    logic                             v1_q;
    logic                             v2_q;
    logic [RIW-1:0]                   idx1_q;
    logic [RIW-1:0]                   idx2_q;
    logic [RIW-1:0]                   row_sel;
    row_t                             qbuf_q [ROWS];
    logic [RIW-1:0]                   row_ptr_q;
    logic                             last_row;
    logic                             done_q;
    logic                             start_accept;
    logic                             beat_accept;
    logic                             out_accept;
    logic                             issue;
    logic [COLS-1:0][ACC_WIDTH-1:0]   lane_acc;
    row_t                             lane_q;

    assign last_row = (row_ptr_q == RIW'(ROWS - 1));

    // Tile controller state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode.
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        start_accept = 1'b0;
        beat_accept  = 1'b0;
        out_accept   = 1'b0;
        issue        = 1'b0;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_accept = 1'b1;
                    state_d      = (k_len_i != '0) ? ACCUM : QUANT;
                end
            end
            ACCUM: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    beat_accept = 1'b1;
                    if (beat_q == k_len_q - K_WIDTH'(1)) begin
                        state_d = QUANT;
                    end
                end
            end
            QUANT: begin
                issue = (qcnt_q < QCW'(ROWS));
                if (qcnt_q == QCW'(ROWS + 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    out_accept = 1'b1;
                    if (last_row) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating multiply-accumulate for every cell of the grid.
    always_comb begin : mac
        logic signed [DATA_WIDTH-1:0] a_s;
        logic signed [DATA_WIDTH-1:0] b_s;
        logic signed [PROD_W-1:0]     prod;
        logic signed [SAT_W-1:0]      wide;
        logic signed [SAT_W-1:0]      sat;
        acc_sat = 1'b0;
        a_s     = '0;
        b_s     = '0;
        prod    = '0;
        wide    = '0;
        sat     = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                a_s  = a_vec_i[i];
                b_s  = b_vec_i[j];
                prod = PROD_W'(a_s) * PROD_W'(b_s);
                wide = SAT_W'(acc_q[i][j]) + SAT_W'(prod);
                sat  = sat_acc(wide, ACC_WIDTH);
                if (sat != wide) begin
                    acc_sat = 1'b1;
                end
                acc_d[i][j] = ACC_WIDTH'(sat);
            end
        end
    end

    // Config latch, beat counter, accumulators and overflow flag.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            k_len_q        <= '0;
            scale_q        <= '0;
            shift_q        <= '0;
            zero_point_q   <= '0;
            beat_q         <= '0;
            acc_overflow_q <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    acc_q[i][j] <= '0;
                end
            end
        end else if (start_accept) begin
            k_len_q        <= k_len_i;
            scale_q        <= scale_i;
            shift_q        <= shift_i;
            zero_point_q   <= zero_point_i;
            beat_q         <= '0;
            acc_overflow_q <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    acc_q[i][j] <= '0;
                end
            end
        end else if (beat_accept) begin
            acc_q  <= acc_d;
            beat_q <= beat_q + K_WIDTH'(1);
            if (acc_sat) begin
                acc_overflow_q <= 1'b1;
            end
        end
    end

    // Row issue select: only meaningful while a row is being issued.
    always_comb begin
        row_sel = issue ? qcnt_q[RIW-1:0] : '0;
        for (int j = 0; j < COLS; j++) begin
            lane_acc[j] = acc_q[row_sel][j];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_lane
        requant_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .acc_i        (lane_acc[j]),
            .scale_i      (scale_q[j]),
            .shift_i      (shift_q[j]),
            .zero_point_i (zero_point_q),
            .q_o          (lane_q[j])
        );
    end

    // Quant sequencing, row-index pipeline, result buffer and drain pointer.
    // NOTE: qbuf is cleared on reset on purpose, so nothing from an aborted
    // tile can ever be presented on out_row.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            qcnt_q    <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            idx1_q    <= '0;
            idx2_q    <= '0;
            row_ptr_q <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                qbuf_q[i] <= '0;
            end
        end else begin
            qcnt_q <= (state_q == QUANT) ? qcnt_q + QCW'(1) : '0;
            v1_q   <= issue;
            idx1_q <= row_sel;
            v2_q   <= v1_q;
            idx2_q <= idx1_q;
            if (v2_q) begin
                qbuf_q[idx2_q] <= lane_q;
            end
            if (start_accept) begin
                row_ptr_q <= '0;
            end else if (out_accept) begin
                row_ptr_q <= last_row ? '0 : row_ptr_q + RIW'(1);
            end
            done_q <= out_accept && last_row;
        end
    end

    assign out_row_o      = out_valid_o ? qbuf_q[row_ptr_q] : '0;
    assign out_row_idx_o  = out_valid_o ? row_ptr_q : '0;
    assign out_last_o     = out_valid_o && last_row;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign acc_overflow_o = acc_overflow_q;

endmodule

// File: doc/systolic_quant_tile_engine.md
# systolic_quant_tile_engine

Parametrised successor to the fixed 4x4 systolic/accumulate/requant datapath. It computes one ROWS x COLS output-stationary tile over a programmable reduction depth and requantises it with per-column scale/shift plus an output zero point. The drained int result is returned row by row over a valid/ready stream. It sits between the operand streamers and the output write-back path, and a tile controller FSM sequences the whole tile.

## Interface
Parameters:
- ROWS, 4, tile rows (a-vector length)
- COLS, 4, tile columns (b-vector length)
- DATA_WIDTH, 8, signed operand/output width
- ACC_WIDTH, 32, signed accumulator width (>= 2*DATA_WIDTH)
- K_WIDTH, 16, width of reduction-length field

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- start  in  1  begin tile; sampled only in IDLE
- k_len  in  K_WIDTH  reduction beats for the tile; latched on start
- scale  in  COLS x ACC_WIDTH  unsigned per-column multiplier; latched on start
- shift  in  COLS x 6  per-column right shift, 0..63; latched on start
- zero_point  in  DATA_WIDTH  signed output offset; latched on start
- in_valid / in_ready  in / out  1  operand beat handshake
- a_vec  in  ROWS x DATA_WIDTH  signed operands
- b_vec  in  COLS x DATA_WIDTH  signed operands
- out_valid / out_ready  out / in  1  result row handshake
- out_row  out  COLS x DATA_WIDTH  signed quantised row
- out_row_idx  out  $clog2(ROWS)  row index of out_row
- out_last  out  1  high with the final row
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last row is accepted
- acc_overflow  out  1  sticky per tile; cleared on start

## Operation
- FSM states are IDLE, ACCUM, QUANT and DRAIN.
- **IDLE:**
  - On start, clear the accumulators and acc_overflow and latch the config.
  - Go to ACCUM if k_len != 0; otherwise go straight to QUANT with all accumulators at zero.
- **ACCUM:**
  - in_ready=1.
  - Each accepted beat does acc[i][j] += a_vec[i]*b_vec[j].
  - Products are full 2*DATA_WIDTH signed and sign-extended before the add.
  - The add saturates to the ACC_WIDTH signed range; any saturation sets acc_overflow.
  - The beat counter reaches k_len on acceptance -> QUANT.
- **QUANT:**
  - Rows 0..ROWS-1 issue one per cycle into a 2-stage per-column pipeline, and results land in qbuf[ROWS][COLS].
  - Stage 1: p = acc * scale, signed, 2*ACC_WIDTH+1 bits.
  - Stage 2, with s = shift[j]:
    - if s > 0, r = (p + 2^(s-1)) >>> s (round half up); if s = 0, r = p;
    - q = r + zero_point, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - -> DRAIN after the last row is written.
- **DRAIN:**
  - Present qbuf[row_ptr] with out_valid=1.
  - On out_valid & out_ready, advance row_ptr.
  - On acceptance of the row with out_last=1, return to IDLE and pulse done.
- Boundary cases:
  - start outside IDLE is ignored.
  - in_valid outside ACCUM is ignored (in_ready=0).
  - reset in any state returns to IDLE and clears the counters, accumulators, qbuf and flags; no partial output is emitted afterwards.

## Timing
- Reset values:
  - in_ready, out_valid, out_last, busy, done, acc_overflow = 0;
  - out_row = 0, out_row_idx = 0.
- start is registered, so ACCUM (in_ready=1) begins in the cycle after start.
- QUANT lasts exactly ROWS+2 cycles. The first out_valid appears in the cycle after QUANT ends.
- Latency, start to first out_valid, with no input stalls: 1 + k_len + ROWS + 2 cycles.
- While out_valid=1 and out_ready=0, out_row, out_row_idx and out_last hold stable.
- With out_ready held high, one row is accepted per cycle.
- done is high in the cycle IDLE is re-entered. A start in that same cycle is accepted.
- acc_overflow updates in the cycle after the offending beat and holds through DRAIN.

## Structure
- Package systolic_quant_pkg holds:
  - state enum (IDLE/ACCUM/QUANT/DRAIN);
  - saturation helper functions sat_acc() and sat_data();
  - SHIFT_WIDTH=6 constant.
- Sub-module requant_lane: one column's 2-stage multiply/round/shift/zero-point/saturate pipeline, instantiated COLS times.
- Accumulator grid, FSM, counters and qbuf live in the top module.

## Test plan
- **Basic:** ROWS=COLS=4, k_len=1, a=[1,2,3,4], b=[1,1,1,1], scale=1, shift=0, zp=0 -> rows [1,1,1,1],[2,2,2,2],[3,3,3,3],[4,4,4,4], out_row_idx 0..3, out_last on row 3, done pulse 1 cycle later.
- **Rounding:** k_len=1, a=[3,-3,5,-5], b=[1,1,1,1], scale=1, shift=1 -> column values 2, -1, 3, -2. Then zp=10 -> 12, 9, 13, 8.
- **Output saturation:** k_len=4, a=127, b=127 (acc 64516), scale=1, shift=0 -> 127. Then a=-128, b=127 -> -128.
- **Accumulator overflow:** ACC_WIDTH=16, k_len=3, a=b=127 -> acc saturates at 32767, acc_overflow=1 after beat 3, cleared by the next start.
- **Backpressure and stalls:**
  - in_valid 50% random -> results match the reference model.
  - out_ready random -> out_row stable while stalled, no row lost or duplicated.
- **k_len=0 and reset:** k_len=0 -> four rows all equal to zero_point. Reset after 2 ACCUM beats -> in_ready/busy=0; the next tile's results are unaffected by the aborted beats.
